// File: rtl/uart_pkg.sv
// uart_pkg: shared state type, data width and baud divisor helper for the buffered UART transmitter
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;

    localparam int DATA_BITS = 8;

    // Rounded clocks-per-bit divisor.
    function automatic int baud_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: dual-pointer RAM FIFO; pushes when full and pops when empty are ignored
//   clk, reset_n   clock, asynchronous active-low reset
//   push, wdata    write request and data
//   pop, rdata     read request; rdata shows the head entry combinationally
//   full, empty    occupancy flags
//   level          occupancy 0..DEPTH (one extra bit separates full from empty)
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign full    = level == (AW + 1)'(DEPTH);
    assign empty   = level == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            level  <= level + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered UART transmitter, 8N1 by default, 8E1 when UART_TX_PARITY_EN is defined
//   clk, reset_n         clock, asynchronous active-low reset
//   in_data, in_valid    byte and valid; transfer when in_valid && in_ready
//   in_ready             FIFO not full
//   tx                   registered serial line, idle high, LSB first
//   busy                 frame in progress or bytes queued
//   fifo_level           FIFO occupancy 0..FIFO_DEPTH
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 115_200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [7:0]                  in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic                        tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
    localparam int             DIV       = baud_div(CLK_HZ, BAUD);
    localparam int             BW        = $clog2(DIV + 1);
    localparam logic [BW-1:0]  BAUD_LAST = BW'(DIV - 1);
    localparam logic [2:0]     LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic [2:0]     S_IDLE    = IDLE;
    localparam logic [2:0]     S_START   = START;
    localparam logic [2:0]     S_DATA    = DATA;
    localparam logic [2:0]     S_STOP    = STOP;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0]     S_PARITY  = PARITY;
    localparam logic [2:0]     S_AFTER   = S_PARITY;
`else
    localparam logic [2:0]     S_AFTER   = S_STOP;
`endif

    logic [2:0]    state, bit_cnt;
    logic [BW-1:0] baud_cnt;
    logic [7:0]    shift_reg, rdata;
    logic          full, empty, bit_end, pop, tx_next;

    uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk    (clk),
        .reset_n(reset_n),
        .push   (in_valid),
        .pop    (pop),
        .wdata  (in_data),
        .rdata  (rdata),
        .full   (full),
        .empty  (empty),
        .level  (fifo_level)
    );

    assign in_ready = !full;
    assign busy     = (state != S_IDLE) || (fifo_level != '0);
    assign bit_end  = baud_cnt == BAUD_LAST;
    // Pop from IDLE, or at the end of STOP so the next start bit follows with no gap.
    assign pop      = !empty && (state == S_IDLE || (state == S_STOP && bit_end));

`ifdef UART_TX_PARITY_EN
    logic parity;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) parity <= 1'b0;
        else if (pop) parity <= ^rdata;
    end

    always_comb tx_next = state == S_START ? 1'b0 : state == S_DATA ? shift_reg[0] :
                          state == S_PARITY ? parity : 1'b1;
`else
    always_comb tx_next = state == S_START ? 1'b0 : state == S_DATA ? shift_reg[0] : 1'b1;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            tx        <= 1'b1;
        end else begin
            tx       <= tx_next;
            baud_cnt <= (state == S_IDLE || bit_end) ? '0 : baud_cnt + BW'(1);
            bit_cnt  <= bit_cnt + 3'(state == S_DATA && bit_end);
            if (pop) shift_reg <= rdata;
            else if (state == S_DATA && bit_end) shift_reg <= shift_reg >> 1;
            case (state)
                S_IDLE:   if (pop) state <= S_START;
                S_START:  if (bit_end) state <= S_DATA;
                S_DATA:   if (bit_end && bit_cnt == LAST_BIT) state <= S_AFTER;
`ifdef UART_TX_PARITY_EN
                S_PARITY: if (bit_end) state <= S_STOP;
`endif
                S_STOP:   if (bit_end) state <= pop ? S_START : S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: self-checking bench for uart_tx_fifo against a frame-level reference model
`timescale 1ns/1ps
module tb_uart_tx_fifo;

    localparam int DEPTH = 16;
`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int D0 = 434;
    localparam int F0 = FB * D0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    bit   chk_en = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    always #10 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Line value of frame bit k for byte b: start, 8 data LSB first, optional even parity, stop.
    function automatic logic bit_of(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[3'(k - 1)];
        if (FB == 11 && k == 9) return ^b;
        return 1'b1;
    endfunction

    // Instance 0 runs at the real 434-clock divisor; instance 1 uses an 8-clock divisor for long sequences.
    for (genvar g = 0; g < 2; g++) begin : u
        localparam int CK = g == 0 ? 50_000_000 : 4_000_000;
        localparam int BD = g == 0 ? 115_200 : 500_000;
        localparam int DV = (CK + BD / 2) / BD;
        localparam int FR = FB * DV;

        logic       iv = 1'b0;
        logic [7:0] id = '0;
        logic       tx, rdy, busy;
        logic [4:0] lvl;

        logic [7:0] q [$];
        int         rem = 0;
        logic [7:0] cur = '0;
        logic       tx_m = 1'b1;

        uart_tx_fifo #(.CLK_HZ(CK), .BAUD(BD), .FIFO_DEPTH(DEPTH)) dut (
            .clk       (clk),
            .reset_n   (rst_n),
            .in_data   (id),
            .in_valid  (iv),
            .in_ready  (rdy),
            .tx        (tx),
            .busy      (busy),
            .fifo_level(lvl)
        );

        // rem = clocks left in the current frame; a new frame starts when idle or on its last clock.
        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                q.delete();
                rem  <= 0;
                cur  <= '0;
                tx_m <= 1'b1;
            end else begin : step
                automatic int n    = q.size();
                automatic bit pop  = n > 0 && rem <= 1;
                automatic bit push = iv && n < DEPTH;
                tx_m <= rem == 0 ? 1'b1 : bit_of(cur, (FR - rem) / DV);
                rem  <= pop ? FR : (rem > 0 ? rem - 1 : 0);
                if (pop) begin
                    cur <= q[0];
                    void'(q.pop_front());
                end
                if (push) q.push_back(id);
            end
        end

        always @(negedge clk) begin
            if (rst_n && chk_en) begin
                check($sformatf("u%0d.tx", g), tx, tx_m);
                check($sformatf("u%0d.in_ready", g), rdy, q.size() < DEPTH);
                check($sformatf("u%0d.busy", g), busy, rem > 0 || q.size() > 0);
                check($sformatf("u%0d.fifo_level", g), lvl, q.size());
            end
        end
    end

    typedef struct {
        logic [7:0] data;
        logic       par;
    } vec_t;

    vec_t tbl [5];

    task automatic drive(input int g, input logic v, input logic [7:0] d);
        if (g == 0) begin
            u[0].iv = v;
            u[0].id = d;
        end else begin
            u[1].iv = v;
            u[1].id = d;
        end
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [7:0] outs(input int g);
        return g == 0 ? {u[0].tx, u[0].rdy, u[0].busy, u[0].lvl} : {u[1].tx, u[1].rdy, u[1].busy, u[1].lvl};
    endfunction

    task automatic wait_idle(input int g, input int limit);
        int n = 0;
        while (outs(g)[5] && n < limit) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("u%0d.idle_within_%0d", g, limit), n < limit, 1'b1);
    endtask

    initial begin
        #4_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int pos;
        logic quiet;
        tbl = '{'{8'h41, 1'b0}, '{8'h43, 1'b1}, '{8'h4F, 1'b1}, '{8'h4B, 1'b0}, '{8'hFF, 1'b0}};
        repeat (3) @(negedge clk);
        for (int g = 0; g < 2; g++) check($sformatf("u%0d.reset_outs", g), outs(g), 8'hC0);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        edges(2);

        // Single frames at DIV=434, sampled mid-bit against hand-written frame contents.
        for (int e = 0; e < 5; e++) begin
            drive(0, 1'b1, tbl[e].data);
            @(posedge clk);
            @(negedge clk);
            drive(0, 1'b0, 8'h00);
            check("single.tx_after_push", u[0].tx, 1'b1);
            edges(1);
            check("single.tx_one_clock", u[0].tx, 1'b1);
            edges(1);
            check("single.start_fall", u[0].tx, 1'b0);
            pos = 2;
            for (int k = 0; k < FB; k++) begin
                edges(2 + k * D0 + D0 / 2 - pos);
                pos = 2 + k * D0 + D0 / 2;
                check($sformatf("single.%02h.bit%0d", tbl[e].data, k), u[0].tx,
                      k == 0 ? 1'b0 : k <= 8 ? tbl[e].data[k - 1] : (FB == 11 && k == 9) ? tbl[e].par : 1'b1);
            end
            edges(F0 - pos);
            check("single.busy_last", u[0].busy, 1'b1);
            edges(1);
            check("single.busy_fall", u[0].busy, 1'b0);
            edges(3);
        end

        // Back-to-back "OK": second start bit directly after the first stop bit.
        drive(0, 1'b1, 8'h4F);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1'b1, 8'h4B);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1'b0, 8'h00);
        check("b2b.level", u[0].lvl, 5'd1);
        edges(F0);
        check("b2b.first_stop_end", u[0].tx, 1'b1);
        edges(1);
        check("b2b.second_start", u[0].tx, 1'b0);
        edges(D0 + D0 / 2);
        check("b2b.second_bit0", u[0].tx, 1'b1);
        edges(2 * F0 - (F0 + 1) - (D0 + D0 / 2) - 1);
        check("b2b.busy_last", u[0].busy, 1'b1);
        edges(1);
        check("b2b.busy_fall", u[0].busy, 1'b0);
        edges(2);

        // Asynchronous reset in the middle of a frame.
        drive(0, 1'b1, 8'h55);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1'b1, 8'hAA);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1'b0, 8'h00);
        edges(1000);
        check("reset.mid_frame_busy", u[0].busy, 1'b1);
        #3 rst_n = 1'b0;
        #1 check("reset.async_outs", outs(0), 8'hC0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        quiet = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            quiet &= u[0].tx & ~u[0].busy;
        end
        check("reset.line_quiet", quiet, 1'b1);

        // Fill the FIFO behind an in-flight frame; the 17th extra byte is dropped.
        drive(1, 1'b1, 8'hA0);
        @(posedge clk);
        @(negedge clk);
        drive(1, 1'b0, 8'h00);
        edges(2);
        for (int j = 0; j < 17; j++) begin
            drive(1, 1'b1, 8'(j + 1));
            @(posedge clk);
            @(negedge clk);
            check($sformatf("full.level%0d", j), u[1].lvl, j < 16 ? 5'(j + 1) : 5'd16);
        end
        check("full.in_ready", u[1].rdy, 1'b0);
        drive(1, 1'b0, 8'h00);

        // Push on the clock where STOP pops: refused, then accepted one clock later.
        pos = 0;
        while (u[1].rem != 1 && pos < 200) begin
            @(negedge clk);
            pos++;
        end
        check("pushpop.reach_stop_end", pos < 200, 1'b1);
        drive(1, 1'b1, 8'hEE);
        @(posedge clk);
        @(negedge clk);
        check("pushpop.level_15", u[1].lvl, 5'd15);
        check("pushpop.ready", u[1].rdy, 1'b1);
        drive(1, 1'b1, 8'hDD);
        @(posedge clk);
        @(negedge clk);
        check("pushpop.level_16", u[1].lvl, 5'd16);
        drive(1, 1'b0, 8'h00);
        wait_idle(1, 3000);

        // Random traffic: a dense phase that saturates the FIFO, then a sparse phase with idle gaps.
        for (int i = 0; i < 4000; i++) begin
            drive(1, $urandom_range(0, i < 2000 ? 9 : 149) == 0, 8'($urandom));
            @(posedge clk);
            @(negedge clk);
        end
        drive(1, 1'b0, 8'h00);
        wait_idle(1, 3000);
        edges(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
